// File: rtl/uart_pkg.sv
// Shared UART TX definitions: line-mux select encodings and parity type constants.
// Used by both the TX control FSM and the TX datapath.
package uart_pkg;

  typedef enum logic [1:0] {
    MUX_START = 2'b00,
    MUX_STOP  = 2'b01,
    MUX_DATA  = 2'b10,
    MUX_PAR   = 2'b11
  } mux_sel_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-rate prescaler: counts enabled cycles and pulses wrap on the last clk of a
// bit period. clr is a synchronous clear that returns the count to zero.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  logic [CW-1:0] prescale_cnt;

  assign wrap = en && (prescale_cnt == CW'(CLKS_PER_BIT - 1));

  // Prescale counter: advances only while enabled, wraps at CLKS_PER_BIT-1
  always_ff @(posedge clk) begin
    if (clr) begin
      prescale_cnt <= '0;
    end else if (en) begin
      prescale_cnt <= wrap ? '0 : prescale_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: latches the parallel word, computes parity, paces each
// frame field at the bit rate (ser_done pulse at field end) and drives the
// registered serial line from the FSM's mux_sel.
// Build option: define UART_TX_PAR_TYP_EN to add the PAR_TYP port (0=even, 1=odd);
// without it parity is fixed even.
module uart_tx_datapath
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              Data_Valid,
`ifdef UART_TX_PAR_TYP_EN
  input  logic              PAR_TYP,
`endif
  input  logic              ser_en,
  input  logic [1:0]        mux_sel,
  output logic              ser_done,
  output logic              TX_OUT
);

  localparam int BW = $clog2(DATA_W);

  mux_sel_e          mux;
  logic              wrap;
  logic              active;
  logic              par_bit;
  logic              par_calc;
  logic              line_bit;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     n_last;

  assign mux    = mux_sel_e'(mux_sel);
  assign n_last = (mux == MUX_DATA) ? BW'(DATA_W - 1) : '0;

`ifdef UART_TX_PAR_TYP_EN
  assign par_calc = (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
`else
  assign par_calc = ^P_DATA;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk (clk),
    .clr (rst),
    .en  (ser_en),
    .wrap(wrap)
  );

  // Line mux: value the serial line takes for the current field
  always_comb begin
    line_bit = 1'b1;
    unique case (mux)
      MUX_START: line_bit = 1'b0;
      MUX_STOP:  line_bit = 1'b1;
      MUX_DATA:  line_bit = shreg[0];
      MUX_PAR:   line_bit = par_bit;
      default:   line_bit = 1'b1;
    endcase
  end

  // Bit counter: counts bit periods in the current field, pulses ser_done at its end
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      ser_done <= 1'b0;
    end else begin
      ser_done <= 1'b0;
      if (wrap) begin
        if (bit_cnt == n_last) begin
          bit_cnt  <= '0;
          ser_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Word latch, shifter, frame-active flag and registered serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      par_bit <= 1'b0;
      active  <= 1'b0;
      TX_OUT  <= 1'b1;
    end else begin
      if (wrap && mux == MUX_DATA) begin
        shreg <= {1'b0, shreg[DATA_W-1:1]};
      end
      // A load never coincides with a wrap (counters are at zero when idle),
      // so letting the load override the shift is only a safety ordering.
      if (Data_Valid && !active) begin
        shreg   <= P_DATA;
        par_bit <= par_calc;
        active  <= 1'b1;
      end else if (ser_done && mux == MUX_STOP) begin
        active <= 1'b0;
      end
      TX_OUT <= (ser_en || active) ? line_bit : 1'b1;
    end
  end

endmodule
